// File: rtl/counter_run_ctrl_if.sv
// Control/status bundle between lab control logic and the counter run
// controller. The master drives the run commands; the slave (the controller)
// returns the counter controls and run status.
interface counter_run_ctrl_if #(
  parameter int WIDTH = 2,
  parameter int LEN_W = 8
);
  logic             start;
  logic             stop;
  logic             pause;
  logic [LEN_W-1:0] length;
  logic             cnt_clr;
  logic             cnt_en;
  logic [WIDTH-1:0] value;
  logic [LEN_W-1:0] wraps;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output start, stop, pause, length,
    input  cnt_clr, cnt_en, value, wraps, busy, done, aborted
  );

  modport slave (
    input  start, stop, pause, length,
    output cnt_clr, cnt_en, value, wraps, busy, done, aborted
  );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run controller for a mod-2^WIDTH counter. A run latches its length, clears
// the counter for one cycle, then enables it for exactly that many cycles,
// with pause/resume and abort. A mirror of the counter value and the number
// of wrap-arounds are kept for the lab control logic.
module counter_run_ctrl #(
  parameter int WIDTH = 2,
  parameter int LEN_W = 8
) (
  input logic                clock,
  input logic                reset,
  counter_run_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    st_idle,
    st_clear,
    st_run,
    st_pause,
    st_done
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [WIDTH-1:0] VAL_ONE = WIDTH'(1);

  state_t           state_reg,   state_next;
  logic [LEN_W-1:0] len_reg,     len_next;
  logic [LEN_W-1:0] ticks_reg,   ticks_next;
  logic [WIDTH-1:0] value_reg,   value_next;
  logic [LEN_W-1:0] wraps_reg,   wraps_next;
  logic             aborted_reg, aborted_next;

  // State and run bookkeeping registers; reset returns everything to idle/zero
  // without touching the counter itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= st_idle;
      len_reg     <= '0;
      ticks_reg   <= '0;
      value_reg   <= '0;
      wraps_reg   <= '0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      ticks_reg   <= ticks_next;
      value_reg   <= value_next;
      wraps_reg   <= wraps_next;
      aborted_reg <= aborted_next;
    end
  end

  // Next-state and bookkeeping: stop beats completion, completion beats pause.
  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    ticks_next   = ticks_reg;
    value_next   = value_reg;
    wraps_next   = wraps_reg;
    aborted_next = 1'b0;

    case (state_reg)
      st_idle: begin
        if (bus.start) begin
          wraps_next = '0;
          if (bus.length != '0) begin
            state_next = st_clear;
            len_next   = bus.length;
            ticks_next = '0;
          end else begin
            // Zero-length run completes without touching the counter.
            state_next = st_done;
          end
        end
      end

      st_clear: begin
        value_next = '0;
        if (bus.stop) begin
          state_next   = st_idle;
          aborted_next = 1'b1;
        end else begin
          state_next = st_run;
        end
      end

      st_run: begin
        // The counter is enabled this cycle whatever happens next, so the
        // mirror advances even on a stop or pause cycle.
        ticks_next = ticks_reg + LEN_ONE;
        value_next = value_reg + VAL_ONE;
        if (value_reg == '1 && wraps_reg != '1) begin
          wraps_next = wraps_reg + LEN_ONE;
        end
        if (bus.stop) begin
          state_next   = st_idle;
          aborted_next = 1'b1;
        end else if (ticks_reg == len_reg - LEN_ONE) begin
          state_next = st_done;
        end else if (bus.pause) begin
          state_next = st_pause;
        end
      end

      st_pause: begin
        if (bus.stop) begin
          state_next   = st_idle;
          aborted_next = 1'b1;
        end else if (!bus.pause) begin
          state_next = st_run;
        end
      end

      st_done: begin
        state_next = st_idle;
      end

      default: begin
        state_next = st_idle;
      end
    endcase
  end

  // Outputs decode straight from registers so they are glitch-free and drop
  // together with the asynchronous reset.
  assign bus.cnt_clr = (state_reg == st_clear);
  assign bus.cnt_en  = (state_reg == st_run);
  assign bus.busy    = (state_reg == st_clear) || (state_reg == st_run) ||
                       (state_reg == st_pause);
  assign bus.done    = (state_reg == st_done);
  assign bus.aborted = aborted_reg;
  assign bus.value   = value_reg;
  assign bus.wraps   = wraps_reg;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl: each run is described by per-cycle
// masks for start/pause/stop, the outputs are traced cycle by cycle and the
// traces compared with hand-computed patterns.
module tb_counter_run_ctrl;

  localparam int WIDTH = 2;
  localparam int LEN_W = 8;

  logic clock;
  logic reset;

  counter_run_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  counter_run_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [31:0]      clr_tr, en_tr, done_tr, abort_tr, busy_tr;
  logic [WIDTH-1:0] val_tr [0:31];
  logic [LEN_W-1:0] wr_tr  [0:31];

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one run: cycle 0 is the first negedge; inputs for cycle c are set
  // at its negedge and outputs of cycle c are sampled there first.
  task automatic run_test(input string name, input logic [LEN_W-1:0] len,
                          input logic [LEN_W-1:0] late_len,
                          input logic [31:0] start_m, input logic [31:0] pause_m,
                          input logic [31:0] stop_m, input int ncyc);
    clr_tr = '0; en_tr = '0; done_tr = '0; abort_tr = '0; busy_tr = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      clr_tr[c]   = bus.cnt_clr;
      en_tr[c]    = bus.cnt_en;
      done_tr[c]  = bus.done;
      abort_tr[c] = bus.aborted;
      busy_tr[c]  = bus.busy;
      val_tr[c]   = bus.value;
      wr_tr[c]    = bus.wraps;
      bus.start  = start_m[c];
      bus.pause  = pause_m[c];
      bus.stop   = stop_m[c];
      bus.length = (c == 0) ? len : late_len;
    end
    $display("run %s: len=%0d en=%08h done=%08h aborted=%08h", name, len, en_tr, done_tr, abort_tr);
  endtask

  int exp_val [5] = '{1, 2, 3, 0, 1};

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.length = '0;
    reset = 1'b1;
    #3 reset = 1'b0;

    // 1: reset state and idle hold
    repeat (3) @(negedge clock);
    check("reset_outputs", {bus.busy, bus.cnt_clr, bus.cnt_en, bus.done, bus.aborted,
                            bus.value, bus.wraps}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_hold", {bus.busy, bus.cnt_clr, bus.cnt_en, bus.done, bus.aborted,
                          bus.value, bus.wraps}, 32'h0);
    end

    // 2: length 5, length changed mid-run must be ignored
    run_test("len5", 8'd5, 8'd3, 32'h1, 32'h0, 32'h0, 9);
    check("t2_clr", clr_tr, 32'h0000_0002);
    check("t2_en", en_tr, 32'h0000_007C);
    check("t2_done", done_tr, 32'h0000_0080);
    check("t2_abort", abort_tr, 32'h0);
    check("t2_busy", busy_tr, 32'h0000_007E);
    for (int i = 0; i < 5; i++) check("t2_value_seq", 32'(val_tr[3+i]), 32'(exp_val[i]));
    check("t2_wraps", 32'(wr_tr[7]), 32'd1);
    check("t2_value_sticky", 32'(val_tr[8]), 32'd1);
    check("t2_wraps_sticky", 32'(wr_tr[8]), 32'd1);

    // 5: zero length -> immediate done, wraps cleared, value held
    run_test("len0", 8'd0, 8'd0, 32'h1, 32'h0, 32'h0, 4);
    check("t5_clr", clr_tr, 32'h0);
    check("t5_en", en_tr, 32'h0);
    check("t5_done", done_tr, 32'h0000_0002);
    check("t5_busy", busy_tr, 32'h0);
    check("t5_wraps", 32'(wr_tr[1]), 32'd0);
    check("t5_value", 32'(val_tr[2]), 32'd1);

    // 3: length 8 with pause high in cycles 4..6
    run_test("len8_pause", 8'd8, 8'd2, 32'h1, 32'h0000_0070, 32'h0, 15);
    check("t3_clr", clr_tr, 32'h0000_0002);
    check("t3_en", en_tr, 32'h0000_1F1C);
    check("t3_done", done_tr, 32'h0000_2000);
    check("t3_busy", busy_tr, 32'h0000_1FFE);
    check("t3_value_paused", 32'(val_tr[6]), 32'd3);
    check("t3_wraps", 32'(wr_tr[13]), 32'd2);
    check("t3_value_end", 32'(val_tr[13]), 32'd0);

    // 4: length 6, stop during the second enable cycle
    run_test("len6_stop", 8'd6, 8'd6, 32'h1, 32'h0, 32'h0000_0008, 8);
    check("t4_en", en_tr, 32'h0000_000C);
    check("t4_abort", abort_tr, 32'h0000_0010);
    check("t4_done", done_tr, 32'h0);
    check("t4_busy", busy_tr, 32'h0000_000E);
    check("t4_value", 32'(val_tr[4]), 32'd2);
    check("t4_wraps", 32'(wr_tr[4]), 32'd0);

    // start held high across a run: second run only after DONE->IDLE
    run_test("len1_held", 8'd1, 8'd1, 32'h0000_001F, 32'h0, 32'h0, 10);
    check("held_clr", clr_tr, 32'h0000_0022);
    check("held_en", en_tr, 32'h0000_0044);
    check("held_done", done_tr, 32'h0000_0088);

    // 6: async reset during RUN, then a normal run
    run_test("len6_pre_reset", 8'd6, 8'd6, 32'h1, 32'h0, 32'h0, 4);
    check("t6_en_before", 32'(en_tr[3]), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_en", 32'(bus.cnt_en), 32'd0);
    check("t6_async_busy", 32'(bus.busy), 32'd0);
    check("t6_async_value", 32'(bus.value), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_test("len5_after_reset", 8'd5, 8'd5, 32'h1, 32'h0, 32'h0, 9);
    check("t6_clr", clr_tr, 32'h0000_0002);
    check("t6_en", en_tr, 32'h0000_007C);
    check("t6_done", done_tr, 32'h0000_0080);
    check("t6_wraps", 32'(wr_tr[8]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
